mc_control_unit_v2: RTL and testbench
=====================================

// Module: mc_control_unit_v2
// PURPOSE
//  Parametrised multicycle RV32I control FSM, successor to the single-config control unit.
//  Adds a memory req/ready handshake with bus timeout, byte-enable generation and misalign
//  detection, a trap path (illegal/misaligned/timeout/system) and an optional mul/div wait state.
//  Sits between the instruction register fields and the multicycle datapath muxes, PC and regfile.
// PARAMETERS
//  MEM_TIMEOUT    255  cycles a memory wait state may last without mem_ready; 0 = wait forever
//  MISALIGN_TRAP  1    1 = misaligned load/store traps; 0 = access proceeds aligned down (addr_lo ignored)
// PORTS
//  clock        in  1  single clock, all state on posedge
//  reset        in  1  asynchronous, active-low reset (0 = in reset)
//  op           in  7  IR[6:0];  funct3 in 3 IR[14:12];  funct7_b0 in 1 IR[25] (M-ext select)
//  addr_lo      in  2  ALU result [1:0], valid in MEMADR
//  mem_ready    in  1  memory completes current request this cycle
//  md_done      in  1  mul/div unit result valid (only used with MULDIV_EN)
//  pc_write, ir_write, reg_write, is_imm, branch  out 1  datapath enables (branch: PC gated by compare)
//  mem_req / mem_we  out 1  memory request / write qualifier;  mem_be out 4  byte enables
//  lorD out 2 (00 PC, 01 ALUOut);  pc_src out 2 (00 ALU, 01 ALUOut, 10 ALU&~1, 11 trap vector)
//  alu_src_a out 2 (00 PC, 01 rs1, 10 oldPC, 11 zero);  alu_src_b out 2 (00 rs2, 01 const 4, 10 imm)
//  alu_op out 2 (00 add, 01 compare, 10 funct);  mem_to_reg out 3 (000 ALUOut, 001 MDR, 010 MD, 011 PC)
//  load_ext out 3  funct3 passed to load extender;  md_start out 1  one-cycle mul/div launch
//  trap out 1  one-cycle pulse;  trap_cause out 2 (00 illegal, 01 misaligned, 10 bus timeout, 11 system)
// BEHAVIOUR
//  - Reset: state=FETCH, all outputs 0, mem_be=0, trap_cause=00, timeout counter 0. Reset mid-request
//    drops mem_req immediately; memory must discard the transfer. Moore outputs except noted Mealy.
//  - Default every cycle: all enables 0, selects 00. States/transitions:
//  FETCH: mem_req, lorD=00, src_a=00, src_b=01. Mealy on mem_ready: ir_write=pc_write=1 -> DECODE.
//  DECODE: src_a=10, src_b=10 (branch/JAL target to ALUOut). op: LOAD/STORE->MEMADR, OP->EXECR,
//    OP-IMM->EXECI, JAL->JAL, JALR(funct3=0)->JALR, BRANCH(funct3!=01x)->BRANCH, AUIPC, LUI,
//    MISC-MEM(0001111)->FETCH (NOP), SYSTEM->TRAP(11), anything else->TRAP(00).
//  MEMADR: src_a=01, src_b=10. funct3[1:0]=11 or store funct3[2]=1 -> TRAP(00). Misaligned (word &&
//    addr_lo!=0, half && addr_lo[0]) with MISALIGN_TRAP=1 -> TRAP(01). Else latch mem_be (byte 0001<<a,
//    half 0011<<a, word 1111) -> MEMREAD (load) or MEMWRITE (store).
//  MEMREAD: mem_req, lorD=01; mem_ready -> MEMWB.  MEMWB: reg_write, mem_to_reg=001, load_ext=funct3.
//  MEMWRITE: mem_req, mem_we, lorD=01; mem_ready -> FETCH.
//  EXECR: src_a=01, alu_op=10 -> ALUWB (funct7_b0 handled per CONFIGURATION).
//  EXECI: src_a=01, src_b=10, alu_op=10, is_imm -> ALUWB.  ALUWB: reg_write, mem_to_reg=000 -> FETCH.
//  JAL: pc_write, pc_src=01, reg_write, mem_to_reg=011 (PC still holds pc+4) -> FETCH.
//  JALR: src_a=01, src_b=10, pc_src=10, pc_write, reg_write, mem_to_reg=011 -> FETCH.
//  BRANCH: src_a=01, alu_op=01, branch, pc_src=01 -> FETCH.
//  AUIPC: src_a=10, src_b=10 -> ALUWB.  LUI: src_a=11, src_b=10 -> ALUWB.
//  TRAP: trap=1, pc_write, pc_src=11 -> FETCH; trap_cause registered on entry, held until next trap.
//  - Timeout: counter clears on entry to FETCH/MEMREAD/MEMWRITE, increments while mem_ready=0;
//    at count==MEM_TIMEOUT (and MEM_TIMEOUT!=0) -> TRAP(10), mem_req drops. mem_ready on the same
//    cycle as expiry wins (normal completion). Counter width $clog2(MEM_TIMEOUT+1), saturating.
// CONFIGURATION
//  MC_CTRL_MULDIV_EN defined: EXECR with funct7_b0=1 pulses md_start -> MD_WAIT; MD_WAIT holds
//    (no timeout) until md_done -> reg_write, mem_to_reg=010 -> FETCH. md_start/md_done ports exist.
//  Undefined: OP with funct7_b0=1 -> TRAP(00); md_start tied 0, md_done ignored, no MD_WAIT state.
// STRUCTURE
//  mc_ctrl_pkg: state enum (6-bit), opcode constants, lorD/pc_src/alu_src/mem_to_reg encodings, trap causes.
//  Sub-module mc_be_gen (combinational): funct3+addr_lo -> mem_be, misaligned, size_illegal.
// TESTING
//  1 LW x1,4(x2): mem_ready after 3 cycles in FETCH and MEMREAD -> mem_be=1111, MEMWB reg_write, mem_to_reg=001.
//  2 SH addr_lo=01, MISALIGN_TRAP=1 -> TRAP, trap_cause=01, pc_src=11, no mem_we ever asserted.
//  3 SB addr_lo=10 -> mem_be=0100, mem_we with mem_req until mem_ready, then FETCH.
//  4 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP cause 10 after 4 cycles; ready on 4th -> DECODE.
//  5 op=1111111 -> TRAP cause 00; MUL (funct7_b0=1) with/without MC_CTRL_MULDIV_EN -> MD_WAIT/TRAP 00.
//  6 reset=0 asserted mid-MEMREAD -> state FETCH, mem_req=0 asynchronously; release -> fetch resumes.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The MD_WAIT state exists only when MC_CTRL_MULDIV_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [5:0] {
    S_FETCH    = 6'd0,
    S_DECODE   = 6'd1,
    S_MEMADR   = 6'd2,
    S_MEMREAD  = 6'd3,
    S_MEMWB    = 6'd4,
    S_MEMWRITE = 6'd5,
    S_EXECR    = 6'd6,
    S_EXECI    = 6'd7,
    S_ALUWB    = 6'd8,
    S_JAL      = 6'd9,
    S_JALR     = 6'd10,
    S_BRANCH   = 6'd11,
    S_AUIPC    = 6'd12,
    S_LUI      = 6'd13,
    S_TRAP     = 6'd14
`ifdef MC_CTRL_MULDIV_EN
    ,
    S_MD_WAIT  = 6'd15
`endif
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL  = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_SYSTEM   = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_MISCMEM  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [1:0] LORD_PC     = 2'b00;
  localparam logic [1:0] LORD_ALUOUT = 2'b01;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_ALU_E  = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] M2R_ALUOUT = 3'b000;
  localparam logic [2:0] M2R_MDR    = 3'b001;
  localparam logic [2:0] M2R_MD     = 3'b010;
  localparam logic [2:0] M2R_PC     = 3'b011;

endpackage

// File: rtl/mc_be_gen.sv
// Byte-enable, misalignment and access-size decode for loads/stores.
module mc_be_gen (
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  logic       is_store_i,
  output logic [3:0] be_o,
  output logic       misaligned_o,
  output logic       size_illegal_o
);

  always_comb begin
    be_o           = 4'b0000;
    misaligned_o   = 1'b0;
    size_illegal_o = (funct3_i[1:0] == 2'b11) || (is_store_i && funct3_i[2]);
    case (funct3_i[1:0])
      2'b00: be_o = 4'b0001 << addr_lo_i;
      2'b01: begin
        // Halfword enables use the aligned-down address so a non-trapping
        // misaligned access still lands on a legal lane pair.
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        misaligned_o = addr_lo_i[0];
      end
      2'b10: begin
        be_o         = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit_v2.sv
// Multicycle RV32I control FSM with memory handshake/timeout, byte enables and trap path.
// Optional mul/div wait state is enabled by defining MC_CTRL_MULDIV_EN.
module mc_control_unit_v2
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 255,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b0_i,
  input  logic [1:0] addr_lo_i,
  input  logic       mem_ready_i,
  input  logic       md_done_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       is_imm_o,
  output logic       branch_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [3:0] mem_be_o,
  output logic [1:0] lorD_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] mem_to_reg_o,
  output logic [2:0] load_ext_o,
  output logic       md_start_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  trap_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             run_q;

  logic [3:0] be_w;
  logic       misal_w;
  logic       size_ill_w;
  logic       wait_st;
  logic       expire;

`ifndef MC_CTRL_MULDIV_EN
  logic unused_md_done;
  assign unused_md_done = md_done_i;
`endif

  mc_be_gen u_be_gen (
    .funct3_i       (funct3_i),
    .addr_lo_i      (addr_lo_i),
    .is_store_i     (op_i == OP_STORE),
    .be_o           (be_w),
    .misaligned_o   (misal_w),
    .size_illegal_o (size_ill_w)
  );

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // Expiry fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready,
  // the cycle the count would reach MEM_TIMEOUT.
  assign expire  = (MEM_TIMEOUT != 0) && wait_st && !mem_ready_i && (cnt_q == CNT_LAST);

  // run_q holds every output at zero while in reset and for the release cycle,
  // so mem_req drops asynchronously and restarts cleanly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      cause_q  <= CAUSE_ILLEGAL;
      cnt_q    <= '0;
      mem_be_q <= 4'b0000;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      mem_be_q <= mem_be_d;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    mem_be_d = mem_be_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready_i) state_d = S_DECODE;
          else if (expire) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          case (op_i)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_OP:             state_d = S_EXECR;
            OP_OPIMM:          state_d = S_EXECI;
            OP_JAL:            state_d = S_JAL;
            OP_AUIPC:          state_d = S_AUIPC;
            OP_LUI:            state_d = S_LUI;
            OP_MISCMEM:        state_d = S_FETCH;
            OP_JALR: begin
              if (funct3_i == 3'b000) state_d = S_JALR;
              else begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
              end
            end
            OP_BRANCH: begin
              if (funct3_i[2:1] != 2'b01) state_d = S_BRANCH;
              else begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
              end
            end
            OP_SYSTEM: begin
              state_d = S_TRAP;
              cause_d = CAUSE_SYSTEM;
            end
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: begin
          if (size_ill_w) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else if (MISALIGN_TRAP && misal_w) begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end else begin
            mem_be_d = be_w;
            state_d  = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
          end
        end
        S_MEMREAD, S_MEMWRITE: begin
          if (mem_ready_i) state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
          else if (expire) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_EXECR: begin
          if (funct7_b0_i) begin
`ifdef MC_CTRL_MULDIV_EN
            state_d = S_MD_WAIT;
`else
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
`endif
          end else begin
            state_d = S_ALUWB;
          end
        end
        S_EXECI, S_AUIPC, S_LUI: state_d = S_ALUWB;
`ifdef MC_CTRL_MULDIV_EN
        S_MD_WAIT: if (md_done_i) state_d = S_FETCH;
`endif
        default: state_d = S_FETCH;
      endcase

      if (state_d != state_q) cnt_d = '0;
      else if (wait_st && !mem_ready_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    is_imm_o     = 1'b0;
    branch_o     = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    lorD_o       = LORD_PC;
    pc_src_o     = PCSRC_ALU;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    mem_to_reg_o = M2R_ALUOUT;
    load_ext_o   = 3'b000;
    md_start_o   = 1'b0;
    trap_o       = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          lorD_o      = LORD_PC;
          alu_src_a_o = SRCA_PC;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_a_o = SRCA_OLDPC;
          alu_src_b_o = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req_o = 1'b1;
          lorD_o    = LORD_ALUOUT;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_MDR;
          load_ext_o   = funct3_i;
        end
        S_MEMWRITE: begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
          lorD_o    = LORD_ALUOUT;
        end
        S_EXECR: begin
          alu_src_a_o = SRCA_RS1;
          alu_op_o    = ALUOP_FUNCT;
`ifdef MC_CTRL_MULDIV_EN
          md_start_o  = funct7_b0_i;
`endif
        end
        S_EXECI: begin
          alu_src_a_o = SRCA_RS1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALUOP_FUNCT;
          is_imm_o    = 1'b1;
        end
        S_ALUWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_ALUOUT;
        end
        S_JAL: begin
          pc_write_o   = 1'b1;
          pc_src_o     = PCSRC_ALUOUT;
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_PC;
        end
        S_JALR: begin
          alu_src_a_o  = SRCA_RS1;
          alu_src_b_o  = SRCB_IMM;
          pc_src_o     = PCSRC_ALU_E;
          pc_write_o   = 1'b1;
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_PC;
        end
        S_BRANCH: begin
          alu_src_a_o = SRCA_RS1;
          alu_op_o    = ALUOP_CMP;
          branch_o    = 1'b1;
          pc_src_o    = PCSRC_ALUOUT;
        end
        S_AUIPC: begin
          alu_src_a_o = SRCA_OLDPC;
          alu_src_b_o = SRCB_IMM;
        end
        S_LUI: begin
          alu_src_a_o = SRCA_ZERO;
          alu_src_b_o = SRCB_IMM;
        end
        S_TRAP: begin
          trap_o     = 1'b1;
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_TRAP;
        end
`ifdef MC_CTRL_MULDIV_EN
        S_MD_WAIT: begin
          reg_write_o  = md_done_i;
          mem_to_reg_o = M2R_MD;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mem_be_o     = mem_be_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// Directed bench for mc_control_unit_v2 (MEM_TIMEOUT=4, MISALIGN_TRAP=1).
module tb_mc_control_unit_v2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic [1:0] alo;
  logic       rdy;
  logic       mdd;
  logic       pc_write, ir_write, reg_write, is_imm, branch, mem_req, mem_we, md_start, trap;
  logic [3:0] mem_be;
  logic [1:0] lord, pc_src, src_a, src_b, alu_op, cause;
  logic [2:0] m2r, load_ext;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_unit_v2 #(.MEM_TIMEOUT(4), .MISALIGN_TRAP(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(f3), .funct7_b0_i(f7),
    .addr_lo_i(alo), .mem_ready_i(rdy), .md_done_i(mdd),
    .pc_write_o(pc_write), .ir_write_o(ir_write), .reg_write_o(reg_write),
    .is_imm_o(is_imm), .branch_o(branch), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .lorD_o(lord), .pc_src_o(pc_src), .alu_src_a_o(src_a),
    .alu_src_b_o(src_b), .alu_op_o(alu_op), .mem_to_reg_o(m2r), .load_ext_o(load_ext),
    .md_start_o(md_start), .trap_o(trap), .trap_cause_o(cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: instruction arrives at once, DECODE, then lands in the dispatched state.
  task automatic fetch_decode(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
    op = o; f3 = fn3; f7 = fn7; rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [35:0] all_out;
    rst_n = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0; alo = 2'd0; rdy = 1'b0; mdd = 1'b0;
    #3;
    all_out = {pc_write, ir_write, reg_write, is_imm, branch, mem_req, mem_we, md_start, trap,
               mem_be, lord, pc_src, src_a, src_b, alu_op, cause, m2r, load_ext};
    n_vec++;
    if (all_out !== 36'd0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    tick(); tick();
    rdy = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, ir_write, src_b} !== 4'b0000) begin
      n_err++; $display("FAIL reset_hold got=%b exp=0000", {mem_req, ir_write, src_b});
    end
    rdy = 1'b0;
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({mem_req, lord, src_a, src_b, ir_write} !== 8'b1_00_00_01_0) begin
      n_err++; $display("FAIL reset_release_fetch got=%b exp=10000010", {mem_req, lord, src_a, src_b, ir_write});
    end
  endtask

  task automatic test_lw();
    op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; alo = 2'b00; rdy = 1'b0;
    tick(); tick();
    rdy = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, ir_write, pc_write} !== 3'b111) begin
      n_err++; $display("FAIL lw_fetch_ready got=%b exp=111", {mem_req, ir_write, pc_write});
    end
    tick(); rdy = 1'b0; #1;
    n_vec++;
    if ({mem_req, src_a, src_b} !== 5'b0_10_10) begin
      n_err++; $display("FAIL lw_decode got=%b exp=01010", {mem_req, src_a, src_b});
    end
    tick();
    n_vec++;
    if ({src_a, src_b} !== 4'b01_10) begin
      n_err++; $display("FAIL lw_memadr got=%b exp=0110", {src_a, src_b});
    end
    tick();
    n_vec++;
    if ({mem_req, mem_we, lord, mem_be} !== 8'b1_0_01_1111) begin
      n_err++; $display("FAIL lw_memread got=%b exp=10011111", {mem_req, mem_we, lord, mem_be});
    end
    tick(); tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    n_vec++;
    if ({reg_write, m2r, load_ext, mem_req} !== 8'b1_001_010_0) begin
      n_err++; $display("FAIL lw_memwb got=%b exp=10010100", {reg_write, m2r, load_ext, mem_req});
    end
    tick();
  endtask

  task automatic test_sh_misalign();
    fetch_decode(7'b0100011, 3'b001, 1'b0);
    alo = 2'b01;
    #1;
    n_vec++;
    if ({mem_we, mem_req} !== 2'b00) begin n_err++; $display("FAIL sh_memadr_we got=%b exp=00", {mem_we, mem_req}); end
    tick();
    n_vec++;
    if ({trap, pc_write, pc_src, cause, mem_we, mem_req} !== 8'b1_1_11_01_0_0) begin
      n_err++; $display("FAIL sh_trap got=%b exp=11110100", {trap, pc_write, pc_src, cause, mem_we, mem_req});
    end
    tick();
    n_vec++;
    if ({trap, cause, mem_req, mem_we} !== 5'b0_01_1_0) begin
      n_err++; $display("FAIL sh_after_trap got=%b exp=00110", {trap, cause, mem_req, mem_we});
    end
  endtask

  task automatic test_alu_flow();
    fetch_decode(7'b0010011, 3'b000, 1'b0);
    n_vec++;
    if ({is_imm, src_a, src_b, alu_op} !== 7'b1_01_10_10) begin
      n_err++; $display("FAIL addi_execi got=%b exp=1011010", {is_imm, src_a, src_b, alu_op});
    end
    tick();
    n_vec++;
    if ({reg_write, m2r} !== 4'b1_000) begin n_err++; $display("FAIL addi_aluwb got=%b exp=1000", {reg_write, m2r}); end
    tick();
    fetch_decode(7'b1101111, 3'b000, 1'b0);
    n_vec++;
    if ({pc_write, pc_src, reg_write, m2r} !== 7'b1_01_1_011) begin
      n_err++; $display("FAIL jal got=%b exp=1011011", {pc_write, pc_src, reg_write, m2r});
    end
    tick();
    fetch_decode(7'b1100011, 3'b001, 1'b0);
    n_vec++;
    if ({branch, alu_op, pc_src, pc_write, src_a} !== 8'b1_01_01_0_01) begin
      n_err++; $display("FAIL bne got=%b exp=10101001", {branch, alu_op, pc_src, pc_write, src_a});
    end
    tick();
    fetch_decode(7'b0110111, 3'b000, 1'b0);
    n_vec++;
    if ({src_a, src_b, reg_write} !== 5'b11_10_0) begin
      n_err++; $display("FAIL lui got=%b exp=11100", {src_a, src_b, reg_write});
    end
    tick(); tick();
    fetch_decode(7'b1100111, 3'b001, 1'b0);
    n_vec++;
    if ({trap, cause} !== 3'b1_00) begin n_err++; $display("FAIL jalr_bad_f3 got=%b exp=100", {trap, cause}); end
    tick();
  endtask

  task automatic test_sb();
    fetch_decode(7'b0100011, 3'b000, 1'b0);
    alo = 2'b10;
    tick();
    n_vec++;
    if ({mem_be, mem_we, mem_req, lord} !== 8'b0100_1_1_01) begin
      n_err++; $display("FAIL sb_memwrite got=%b exp=01001101", {mem_be, mem_we, mem_req, lord});
    end
    tick();
    rdy = 1'b1;
    #1;
    n_vec++;
    if ({mem_we, mem_req} !== 2'b11) begin n_err++; $display("FAIL sb_hold got=%b exp=11", {mem_we, mem_req}); end
    tick();
    rdy = 1'b0;
    #1;
    n_vec++;
    if ({mem_we, mem_req, lord, trap} !== 5'b0_1_00_0) begin
      n_err++; $display("FAIL sb_done_fetch got=%b exp=01000", {mem_we, mem_req, lord, trap});
    end
  endtask

  task automatic test_timeout();
    rdy = 1'b0; op = 7'b0001111;
    tick(); tick(); tick();
    n_vec++;
    if ({mem_req, trap} !== 2'b10) begin n_err++; $display("FAIL to_4th_cycle got=%b exp=10", {mem_req, trap}); end
    tick();
    n_vec++;
    if ({trap, cause, mem_req, pc_src} !== 6'b1_10_0_11) begin
      n_err++; $display("FAIL to_trap got=%b exp=110011", {trap, cause, mem_req, pc_src});
    end
    tick();
    tick(); tick(); tick();
    rdy = 1'b1;
    #1;
    n_vec++;
    if ({ir_write, pc_write} !== 2'b11) begin n_err++; $display("FAIL to_ready_wins got=%b exp=11", {ir_write, pc_write}); end
    tick();
    rdy = 1'b0;
    #1;
    n_vec++;
    if ({trap, src_a, src_b} !== 5'b0_10_10) begin
      n_err++; $display("FAIL to_decode got=%b exp=01010", {trap, src_a, src_b});
    end
    tick();
    n_vec++;
    if ({mem_req, trap} !== 2'b10) begin n_err++; $display("FAIL fence_nop got=%b exp=10", {mem_req, trap}); end
  endtask

  task automatic test_illegal();
    fetch_decode(7'b1111111, 3'b000, 1'b0);
    n_vec++;
    if ({trap, cause} !== 3'b1_00) begin n_err++; $display("FAIL illegal_op got=%b exp=100", {trap, cause}); end
    tick();
    fetch_decode(7'b1110011, 3'b000, 1'b0);
    n_vec++;
    if ({trap, cause} !== 3'b1_11) begin n_err++; $display("FAIL system got=%b exp=111", {trap, cause}); end
    tick();
  endtask

  task automatic test_muldiv();
    fetch_decode(7'b0110011, 3'b000, 1'b1);
    n_vec++;
`ifdef MC_CTRL_MULDIV_EN
    if ({md_start, alu_op, src_a} !== 5'b1_10_01) begin
      n_err++; $display("FAIL mul_execr got=%b exp=11001", {md_start, alu_op, src_a});
    end
    tick(); tick();
    n_vec++;
    if ({reg_write, trap, mem_req} !== 3'b000) begin
      n_err++; $display("FAIL mul_wait got=%b exp=000", {reg_write, trap, mem_req});
    end
    mdd = 1'b1;
    #1;
    n_vec++;
    if ({reg_write, m2r} !== 4'b1_010) begin n_err++; $display("FAIL mul_done got=%b exp=1010", {reg_write, m2r}); end
    tick();
    mdd = 1'b0;
`else
    if ({md_start, alu_op, src_a} !== 5'b0_10_01) begin
      n_err++; $display("FAIL mul_execr got=%b exp=01001", {md_start, alu_op, src_a});
    end
    tick();
    n_vec++;
    if ({trap, cause} !== 3'b1_00) begin n_err++; $display("FAIL mul_trap got=%b exp=100", {trap, cause}); end
    tick();
`endif
    fetch_decode(7'b0110011, 3'b000, 1'b0);
    tick();
    n_vec++;
    if ({reg_write, m2r, trap} !== 5'b1_000_0) begin
      n_err++; $display("FAIL add_aluwb got=%b exp=10000", {reg_write, m2r, trap});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    fetch_decode(7'b0000011, 3'b010, 1'b0);
    alo = 2'b00;
    tick();
    n_vec++;
    if ({mem_req, lord} !== 3'b1_01) begin n_err++; $display("FAIL mid_memread got=%b exp=101", {mem_req, lord}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, lord, mem_be} !== 7'b0_00_0000) begin
      n_err++; $display("FAIL mid_async_drop got=%b exp=0000000", {mem_req, lord, mem_be});
    end
    tick();
    rst_n = 1'b1;
    tick();
    rdy = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, lord, ir_write, src_b} !== 6'b1_00_1_01) begin
      n_err++; $display("FAIL mid_resume got=%b exp=100101", {mem_req, lord, ir_write, src_b});
    end
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sh_misalign();
    test_alu_flow();
    test_sb();
    test_timeout();
    test_illegal();
    test_muldiv();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
